// File: rtl/br_write_arbiter.sv
// Two-requester arbiter for the BR write port: captures the winner, then issues one write pulse after HOLD_CYCLES.
// Build option: define BR_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
//
// state  | meaning
// IDLE   | waiting for a request; captured addr/data/selector held from the previous transfer
// SETTLE | winner captured, counting settle cycles
// WRITE  | o_e_write_br high for this one cycle
module br_write_arbiter #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt1,
   output logic              o_e_write_br,
   output logic [ADDR_W-1:0] o_addr_br,
   output logic [DATA_W-1:0] o_data_br,
   output logic              selector_demux,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, WRITE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(HOLD_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       last;
   logic       win;

`ifdef BR_ARB_ROUND_ROBIN_EN
   // On a tie the requester that did not win last time goes first.
   always_comb begin
      win = req1;
      if (req0 && req1) win = ~last;
   end
`else
   logic rr_last_unused;
   assign rr_last_unused = last;

   always_comb begin
      win = ~req0;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         last           <= 1'b1;
         gnt0           <= 1'b0;
         gnt1           <= 1'b0;
         o_e_write_br   <= 1'b0;
         o_addr_br      <= '0;
         o_data_br      <= '0;
         selector_demux <= 1'b0;
         busy           <= 1'b0;
      end else begin
         gnt0         <= 1'b0;
         gnt1         <= 1'b0;
         o_e_write_br <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  o_addr_br      <= win ? addr1 : addr0;
                  o_data_br      <= win ? data1 : data0;
                  selector_demux <= win;
                  gnt0           <= ~win;
                  gnt1           <= win;
                  last           <= win;
                  cnt            <= 4'd0;
                  busy           <= 1'b1;
                  state          <= SETTLE;
               end
            end
            SETTLE: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_CNT) begin
                  o_e_write_br <= 1'b1;
                  state        <= WRITE;
               end
            end
            WRITE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
